// File: rtl/softmax_pkg.sv
// -----------------------------------------------------------------------------
// softmax_pkg
//   Shared constants for the softmax datapath front end.
//   - Q4.12 signed element format (DATA_W bits, Q_FRAC fractional bits)
//   - Q412_MIN: most-negative Q4.12 value, used to pad short vectors so that
//     pad slots can never win a max or contribute to a softmax sum
//   - FSM state encoding for the input packer
// -----------------------------------------------------------------------------
package softmax_pkg;

    localparam int Q_FRAC = 12;
    localparam int DATA_W = 16;

    localparam logic [DATA_W-1:0] Q412_MIN = 16'h8000;

    // Packer FSM encoding, kept as plain constants so that older tools and
    // netlist consumers see a simple one-bit state register.
    localparam logic STATE_FILL = 1'b0;
    localparam logic STATE_HOLD = 1'b1;

endpackage : softmax_pkg

// File: rtl/softmax_input_packer_max_tracker.sv
// -----------------------------------------------------------------------------
// max_tracker
//   Running signed maximum register.
//   Ports:
//     clk    in   clock, rising edge
//     rst    in   asynchronous active-low reset (clears the max to 0)
//     en     in   sample din this cycle
//     init   in   with en: load din unconditionally (first element of a vector)
//     din    in   signed element
//     max_q  out  registered running maximum
// -----------------------------------------------------------------------------
module max_tracker #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         init,
    input  logic [W-1:0] din,
    output logic [W-1:0] max_q
);

    logic [W-1:0] max_reg;
    logic [W-1:0] max_next;

    always_comb begin
        max_next = max_reg;
        if (en) begin
            if (init || ($signed(din) > $signed(max_reg))) begin
                max_next = din;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            max_reg <= '0;
        end else begin
            max_reg <= max_next;
        end
    end

    assign max_q = max_reg;

endmodule : max_tracker

// File: rtl/softmax_input_packer.sv
// -----------------------------------------------------------------------------
// softmax_input_packer
//   Stream-to-vector front end for the softmax core. Collects up to N signed
//   Q4.12 elements from a valid/ready stream into a flattened vector, tracks
//   the signed maximum on the fly and hands the vector over with its length.
//   Short vectors (in_last) are padded with Q412_MIN.
//   Ports:
//     clk        in   clock, rising edge
//     rst        in   asynchronous active-low reset
//     in_valid   in   upstream element valid
//     in_ready   out  packer accepts an element (registered-state decode)
//     in_x       in   signed Q4.12 element
//     in_last    in   element closes a short vector
//     flush      in   abort a partially filled vector (FILL only)
//     out_valid  out  vector outputs hold a complete vector
//     out_ready  in   downstream takes the vector
//     in_x_flat  out  element k at bits [k*W +: W]
//     max_x      out  signed max of the real elements
//     out_len    out  number of real elements (1..N)
// -----------------------------------------------------------------------------
module softmax_input_packer
    import softmax_pkg::*;
#(
    parameter int N = 4,
    parameter int W = DATA_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_x,
    input  logic                   in_last,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N*W-1:0]         in_x_flat,
    output logic [W-1:0]           max_x,
    output logic [$clog2(N+1)-1:0] out_len
);

    localparam int IDX_W = $clog2(N);
    localparam int LEN_W = $clog2(N+1);

    logic             state_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [LEN_W-1:0] out_len_reg;
    logic [W-1:0]     slot_reg [N];

    logic             accept;
    logic             take;
    logic             complete;

    // Both handshake outputs come straight from the state register.
    assign in_ready  = (state_reg == STATE_FILL);
    assign out_valid = (state_reg == STATE_HOLD);

    assign accept   = in_valid && in_ready;
    // flush wins over a simultaneous accept: the element is dropped.
    assign take     = accept && !flush;
    assign complete = (idx_reg == IDX_W'(N-1)) || in_last;

    // FSM, write index and vector length.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= STATE_FILL;
            idx_reg     <= '0;
            out_len_reg <= '0;
        end else begin
            case (state_reg)
                STATE_FILL: begin
                    if (flush) begin
                        idx_reg <= '0;
                    end else if (take) begin
                        if (complete) begin
                            idx_reg     <= '0;
                            out_len_reg <= LEN_W'(idx_reg) + LEN_W'(1);
                            state_reg   <= STATE_HOLD;
                        end else begin
                            idx_reg <= idx_reg + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    if (out_ready) begin
                        state_reg <= STATE_FILL;
                    end
                end
            endcase
        end
    end

    // Per-slot storage: the slot at idx takes the element; on the closing
    // accept every slot above idx is padded on the same edge.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slot
            localparam logic [IDX_W-1:0] SLOT = IDX_W'(gi);

            logic wr_en;
            logic pad_en;

            assign wr_en  = take && (idx_reg == SLOT);
            assign pad_en = take && complete && (SLOT > idx_reg);

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    slot_reg[gi] <= '0;
                end else if (wr_en) begin
                    slot_reg[gi] <= in_x;
                end else if (pad_en) begin
                    slot_reg[gi] <= Q412_MIN;
                end
            end

            assign in_x_flat[gi*W +: W] = slot_reg[gi];
        end
    endgenerate

    max_tracker #(
        .W (W)
    ) u_max_tracker (
        .clk   (clk),
        .rst   (rst),
        .en    (take),
        .init  (idx_reg == '0),
        .din   (in_x),
        .max_q (max_x)
    );

    assign out_len = out_len_reg;

endmodule : softmax_input_packer

// File: tb/tb_softmax_input_packer.sv
// -----------------------------------------------------------------------------
// tb_softmax_input_packer
//   Directed bench for softmax_input_packer (N = 4, W = 16). Inputs change
//   1 time unit after the rising edge; outputs are sampled at the same point,
//   i.e. after the edge has settled.
// -----------------------------------------------------------------------------
module tb_softmax_input_packer;

    localparam int N = 4;
    localparam int W = 16;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_x;
    logic            in_last;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [N*W-1:0]  in_x_flat;
    logic [W-1:0]    max_x;
    logic [2:0]      out_len;

    int check_count;
    int error_count;

    softmax_input_packer #(
        .N (N),
        .W (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_last   (in_last),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .in_x_flat (in_x_flat),
        .max_x     (max_x),
        .out_len   (out_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_count++;
        if (obs !== exp) begin
            error_count++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One element over the stream; the packer is in FILL so it is taken on this edge.
    task automatic send(input logic [W-1:0] val, input logic last);
        in_valid = 1'b1;
        in_x     = val;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        $display("sent %h last=%0b", val, last);
    endtask

    // Let the held vector go for one cycle.
    task automatic release_vec();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic check_vec(input string tag, input logic [63:0] flat,
                             input logic [15:0] mx, input logic [2:0] len);
        check_val({tag, "_valid"}, 64'(out_valid), 64'd1);
        check_val({tag, "_ready"}, 64'(in_ready), 64'd0);
        check_val({tag, "_flat"}, in_x_flat, flat);
        check_val({tag, "_max"}, 64'(max_x), 64'(mx));
        check_val({tag, "_len"}, 64'(out_len), 64'(len));
    endtask

    initial begin
        check_count = 0;
        error_count = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_last   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check_val("rst_ready", 64'(in_ready), 64'd1);
        check_val("rst_valid", 64'(out_valid), 64'd0);
        check_val("rst_flat", in_x_flat, 64'd0);
        check_val("rst_max", 64'(max_x), 64'd0);
        check_val("rst_len", 64'(out_len), 64'd0);
        rst = 1'b1;
        tick();

        // 1. Full vector
        send(16'hEC80, 1'b0);
        send(16'hFE18, 1'b0);
        send(16'h2771, 1'b0);
        check_val("t1_valid_before", 64'(out_valid), 64'd0);
        send(16'h15DB, 1'b0);
        check_vec("t1", 64'h15DB_2771_FE18_EC80, 16'h2771, 3'd4);
        release_vec();
        check_val("t1_valid_drop", 64'(out_valid), 64'd0);

        // 2. Short vector
        send(16'h1000, 1'b0);
        send(16'hF000, 1'b1);
        check_vec("t2", 64'h8000_8000_F000_1000, 16'h1000, 3'd2);
        release_vec();

        // 3. All negative
        send(16'h8001, 1'b0);
        send(16'hFFFF, 1'b0);
        send(16'hC000, 1'b0);
        send(16'h9000, 1'b0);
        check_vec("t3", 64'h9000_C000_FFFF_8001, 16'hFFFF, 3'd4);

        // 4. Backpressure with in_valid held high
        in_valid = 1'b1;
        in_x     = 16'h1234;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_val($sformatf("t4_hold%0d_flat", i), in_x_flat, 64'h9000_C000_FFFF_8001);
            check_val($sformatf("t4_hold%0d_ready", i), 64'(in_ready), 64'd0);
        end
        check_val("t4_hold_max", 64'(max_x), 64'hFFFF);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val("t4_valid_drop", 64'(out_valid), 64'd0);
        check_val("t4_ready_back", 64'(in_ready), 64'd1);
        tick();  // 1234 taken into slot 0
        in_valid = 1'b0;
        check_val("t4_slot0", in_x_flat, 64'h9000_C000_FFFF_1234);
        check_val("t4_max_init", 64'(max_x), 64'h1234);
        check_val("t4_not_done", 64'(out_valid), 64'd0);

        // Abort that partial vector.
        flush = 1'b1;
        tick();
        flush = 1'b0;

        // 5. Flush with a simultaneous element
        send(16'h0AAA, 1'b0);
        send(16'h0BBB, 1'b0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_x     = 16'h7FFF;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_val("t5_flush_valid", 64'(out_valid), 64'd0);
        send(16'h0001, 1'b0);
        send(16'h0002, 1'b0);
        send(16'h0003, 1'b0);
        send(16'h0004, 1'b0);
        check_vec("t5", 64'h0004_0003_0002_0001, 16'h0004, 3'd4);

        // 6. Asynchronous reset mid-period while holding
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_val("t6_valid", 64'(out_valid), 64'd0);
        check_val("t6_flat", in_x_flat, 64'd0);
        check_val("t6_ready", 64'(in_ready), 64'd1);
        check_val("t6_max", 64'(max_x), 64'd0);
        #2;
        rst = 1'b1;
        tick();
        send(16'h0100, 1'b0);
        send(16'h0200, 1'b0);
        send(16'h0300, 1'b0);
        send(16'hF000, 1'b0);
        check_vec("t6_after", 64'hF000_0300_0200_0100, 16'h0300, 3'd4);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule : tb_softmax_input_packer
